tick_sched_ctrl: RTL and testbench

- Run-time controller for the clock-divide path: loads the divisor, starts and stops division, and generates either a free-running tick stream or a counted burst.
- Outputs a one-cycle enable pulse (tick_o) and a square wave (clk_div_o) that toggles on every tick.
- Sits between the board control logic (buttons/FSMs) and the downstream logic that consumes the enables.
- New divisors are accepted through a valid/ready handshake and applied only on period boundaries, so no period is ever truncated.

---
 rtl/tick_sched_pkg.sv | 20 ++
 rtl/tick_sched_ctrl_period_counter.sv | 36 +++
 rtl/tick_sched_ctrl.sv | 142 ++++++++++++++
 tb/tb_tick_sched_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler.
// Used by the period counter and the controller.
package tick_sched_pkg;

  localparam int CNT_W_DEF   = 28;
  localparam int BURST_W_DEF = 16;
  localparam int DEF_DIV_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_BURST = 1'b1
  } mode_t;

endpackage

// File: rtl/tick_sched_ctrl_period_counter.sv
// Period counter: counts 0..div and emits a one-cycle tick on the match.
// The counter resets on the match itself, so it can never pass div and wrap.
module period_counter
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = enable_i & (cnt_q == div_i);
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Run-time controller for the clock-divide path: FSM, shadow configuration
// slot and burst tick counter around a single period counter.
module tick_sched_ctrl
  import tick_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk_10MHz_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CNT_W-1:0]   cfg_div_i,
  input  logic               cfg_mode_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               tick_o,
  output logic               clk_div_o,
  output logic               busy_o,
  output logic               done_o
);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0]     div_q, div_d, sh_div_q, sh_div_d;
  logic [BURST_W-1:0]   burst_len_q, burst_len_d, sh_burst_q, sh_burst_d;
  logic [BURST_W-1:0]   burst_run_q, burst_run_d, tick_cnt_q, tick_cnt_d;
  logic                 sh_full_q, sh_full_d;
  logic                 clk_div_q, clk_div_d, busy_q, busy_d;
  logic                 cnt_clear, cnt_en, tick, cfg_hs, done, burst_last;

  period_counter #(.CNT_W(CNT_W)) u_period_counter (
    .clk_i    (clk_10MHz_i),
    .rst_i    (rst_i),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  always_comb begin
    cfg_hs     = cfg_valid_i & ~sh_full_q;
    cnt_clear  = (state_q == IDLE) | stop_i;
    cnt_en     = ~stop_i & ((state_q == RUN) |
                            ((state_q == BURST) & (burst_run_q != '0)));
    burst_last = ({1'b0, tick_cnt_q} + (BURST_W + 1)'(1)) == {1'b0, burst_run_q};
    done       = (state_q == BURST) & ~stop_i &
                 ((burst_run_q == '0) | (tick & burst_last));

    state_d     = state_q;
    mode_d      = mode_q;
    div_d       = div_q;
    burst_len_d = burst_len_q;
    burst_run_d = burst_run_q;
    tick_cnt_d  = tick_cnt_q;
    sh_mode_d   = sh_mode_q;
    sh_div_d    = sh_div_q;
    sh_burst_d  = sh_burst_q;
    sh_full_d   = sh_full_q;

    if (state_q == IDLE) begin
      if (cfg_hs) begin
        div_d       = cfg_div_i;
        mode_d      = mode_t'(cfg_mode_i);
        burst_len_d = cfg_burst_i;
      end
      if (start_i & ~stop_i) begin
        state_d     = (mode_q == MODE_BURST) ? BURST : RUN;
        burst_run_d = burst_len_q;
        tick_cnt_d  = '0;
      end
    end else begin
      if (stop_i | done) begin
        state_d = IDLE;
      end
      if (tick & (state_q == BURST)) begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      // Pending config lands on a period boundary, or as the block goes idle.
      if (sh_full_q & (tick | (state_d == IDLE))) begin
        div_d       = sh_div_q;
        mode_d      = sh_mode_q;
        burst_len_d = sh_burst_q;
        sh_full_d   = 1'b0;
      end
      if (cfg_hs) begin
        if (state_d == IDLE) begin
          div_d       = cfg_div_i;
          mode_d      = mode_t'(cfg_mode_i);
          burst_len_d = cfg_burst_i;
        end else begin
          sh_div_d   = cfg_div_i;
          sh_mode_d  = mode_t'(cfg_mode_i);
          sh_burst_d = cfg_burst_i;
          sh_full_d  = 1'b1;
        end
      end
    end

    clk_div_d = (state_d == IDLE) ? 1'b0 : (tick ? ~clk_div_q : clk_div_q);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= MODE_RUN;
      div_q       <= CNT_W'(DEF_DIV);
      burst_len_q <= BURST_W'(1);
      burst_run_q <= BURST_W'(1);
      tick_cnt_q  <= '0;
      sh_mode_q   <= MODE_RUN;
      sh_div_q    <= '0;
      sh_burst_q  <= '0;
      sh_full_q   <= 1'b0;
      clk_div_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      burst_len_q <= burst_len_d;
      burst_run_q <= burst_run_d;
      tick_cnt_q  <= tick_cnt_d;
      sh_mode_q   <= sh_mode_d;
      sh_div_q    <= sh_div_d;
      sh_burst_q  <= sh_burst_d;
      sh_full_q   <= sh_full_d;
      clk_div_q   <= clk_div_d;
      busy_q      <= busy_d;
    end
  end

  assign tick_o      = tick;
  assign done_o      = done;
  assign clk_div_o   = clk_div_q;
  assign busy_o      = busy_q;
  assign cfg_ready_o = ~sh_full_q;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed bench for tick_sched_ctrl. Slot 0 is the cycle right after the
// edge that samples start_i; a divisor d gives its first tick in slot d.
`timescale 1ns/1ps
module tb_tick_sched_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [27:0] cfg_div;
  logic        cfg_mode;
  logic [15:0] cfg_burst;
  logic        start;
  logic        stop;
  logic        tick;
  logic        clk_div;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  tick_sched_ctrl dut (
    .clk_10MHz_i (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_div_i   (cfg_div),
    .cfg_mode_i  (cfg_mode),
    .cfg_burst_i (cfg_burst),
    .start_i     (start),
    .stop_i      (stop),
    .tick_o      (tick),
    .clk_div_o   (clk_div),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [27:0] d, input logic m, input logic [15:0] b);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_mode  = m;
    cfg_burst = b;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    vectors++;
    if ({tick, clk_div, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {tick, clk_div, busy, done});
    end
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready);
    end
  endtask

  // Default divisor 10: ticks every 11 cycles, a stray start mid-run is ignored.
  task automatic test_free_run();
    logic [3:0] exp_v;
    do_start();
    for (int s = 0; s <= 33; s++) begin
      exp_v = {(s == 10 || s == 21 || s == 32),
               ((s >= 11 && s <= 21) || s >= 33), 1'b1, 1'b0};
      vectors++;
      if ({tick, clk_div, busy, done} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL free_run slot %0d: got %b expected %b", s, {tick, clk_div, busy, done}, exp_v);
      end
      start = (s == 5);
      step();
    end
    start = 1'b0;
    do_stop();
    vectors++;
    if ({tick, clk_div, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL free_run_stop: got %b expected 0000", {tick, clk_div, busy, done});
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_v;
    configure(28'd3, 1'b1, 16'd4);
    do_start();
    for (int s = 0; s <= 16; s++) begin
      exp_v = {(s == 3 || s == 7 || s == 11 || s == 15),
               ((s >= 4 && s <= 7) || (s >= 12 && s <= 15)),
               (s <= 15), (s == 15)};
      vectors++;
      if ({tick, clk_div, busy, done} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL burst slot %0d: got %b expected %b", s, {tick, clk_div, busy, done}, exp_v);
      end
      step();
    end
  endtask

  // Offer div=1 in slot 4 of a div=9 run: the first period keeps its 10 cycles.
  task automatic test_shadow();
    logic [3:0] exp_v;
    configure(28'd9, 1'b0, 16'd1);
    do_start();
    for (int s = 0; s <= 15; s++) begin
      exp_v = {(s == 9 || s == 11 || s == 13 || s == 15),
               ((s >= 10 && s <= 11) || s >= 14), 1'b1,
               (s <= 4 || s >= 10)};
      vectors++;
      if ({tick, clk_div, busy, cfg_ready} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL shadow slot %0d: got %b expected %b", s, {tick, clk_div, busy, cfg_ready}, exp_v);
      end
      if (s == 4) begin
        cfg_valid = 1'b1;
        cfg_div   = 28'd1;
        cfg_mode  = 1'b0;
        cfg_burst = 16'd1;
      end else if (s == 5) begin
        cfg_valid = 1'b0;
      end
      step();
    end
    do_stop();
  endtask

  task automatic test_stop();
    configure(28'd5, 1'b0, 16'd1);
    do_start();
    for (int s = 0; s <= 4; s++) step();
    stop = 1'b1;
    #1;
    vectors++;
    if ({tick, done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL stop_cycle_tick: got %b expected 00", {tick, done});
    end
    step();
    stop = 1'b0;
    vectors++;
    if ({tick, clk_div, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL stop_idle: got %b expected 0000", {tick, clk_div, busy, done});
    end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int s = 0; s <= 2; s++) begin
      vectors++;
      if ({tick, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL start_stop_idle cycle %0d: got %b expected 00", s, {tick, busy});
      end
      step();
    end
    do_start();
    for (int s = 0; s <= 5; s++) begin
      vectors++;
      if (tick !== (s == 5)) begin
        miscompares++;
        $display("[TB] FAIL restart_after_stop slot %0d: got %b expected %b", s, tick, (s == 5));
      end
      step();
    end
    do_stop();
  endtask

  task automatic test_zero_div_burst();
    logic [3:0] exp_v;
    configure(28'd0, 1'b1, 16'd0);
    do_start();
    vectors++;
    if ({tick, busy, done} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL zero_burst_done: got %b expected 011", {tick, busy, done});
    end
    step();
    vectors++;
    if ({tick, busy, done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL zero_burst_idle: got %b expected 000", {tick, busy, done});
    end
    configure(28'd0, 1'b1, 16'd3);
    do_start();
    for (int s = 0; s <= 3; s++) begin
      exp_v = {(s <= 2), (s == 1), (s <= 2), (s == 2)};
      vectors++;
      if ({tick, clk_div, busy, done} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL div0_burst3 slot %0d: got %b expected %b", s, {tick, clk_div, busy, done}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    configure(28'd3, 1'b1, 16'd4);
    do_start();
    for (int s = 0; s <= 4; s++) step();
    vectors++;
    if ({clk_div, busy} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_burst: got %b expected 11", {clk_div, busy});
    end
    #10;
    rst = 1'b1;
    #1;
    vectors++;
    if ({tick, clk_div, busy, done, cfg_ready} !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %b expected 00001", {tick, clk_div, busy, done, cfg_ready});
    end
    step();
    rst = 1'b0;
    step();
    do_start();
    for (int s = 0; s <= 10; s++) begin
      vectors++;
      if (tick !== (s == 10)) begin
        miscompares++;
        $display("[TB] FAIL post_reset_period slot %0d: got %b expected %b", s, tick, (s == 10));
      end
      step();
    end
    do_stop();
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
    test_reset();
    test_free_run();
    test_burst();
    test_shadow();
    test_stop();
    test_zero_div_burst();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
